// File: rtl/pipelined_signed_shift_divider_pkg.sv
// Shared types and the rounding-bias helper for the signed shift divider.
package shift_div_pkg;

   typedef enum logic [1:0] {FLOOR = 2'b00, TRUNC = 2'b01, ROUND = 2'b10, RSVD = 2'b11} mode_t;

   // Wide enough for any supported data width; callers size-cast the result down to N+1 bits.
   localparam int BW = 65;

   // Bias added before the arithmetic shift so that a plain floor shift gives the chosen rounding.
   function automatic logic signed [BW-1:0] bias(input logic signed [BW-1:0] a,
                                                 input int unsigned s,
                                                 input mode_t mode);
      logic signed [BW-1:0] b;
      b = '0;
      case (mode)
         TRUNC:   if (a < 0) b = (BW'(1) << s) - BW'(1);
         ROUND:   if (s > 0) b = BW'(1) << (s - 1);
         default: b = '0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pipelined_signed_shift_divider_stage.sv
// One registered barrel-shifter stage: optional arithmetic shift by DIST plus its valid/ready slot.
module shift_div_stage
   import shift_div_pkg::*;
#(
   parameter int W     = 9,
   parameter int DIST  = 1,
   parameter int TAG_W = 4,
   parameter int SW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [W-1:0]     up_data,
   input  logic [SW-1:0]    up_shamt,
   input  logic [TAG_W-1:0] up_tag,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [W-1:0]     down_data,
   output logic [SW-1:0]    down_shamt,
   output logic [TAG_W-1:0] down_tag
);

   localparam int B = $clog2(DIST);

   logic [W-1:0] shifted;

   // Sign-fill from the top bit of the extended sum; this stage owns shift-amount bit B.
   assign shifted  = up_shamt[B] ? {{DIST{up_data[W-1]}}, up_data[W-1:DIST]} : up_data;
   assign up_ready = !down_valid || down_ready;

   // Slot register: loads when empty or draining, otherwise holds everything stable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         down_valid <= 1'b0;
         down_data  <= '0;
         down_shamt <= '0;
         down_tag   <= '0;
      end else if (up_ready) begin
         down_valid <= up_valid;
         if (up_valid) begin
            down_data  <= shifted;
            down_shamt <= up_shamt;
            down_tag   <= up_tag;
         end
      end
   end

endmodule

// File: rtl/pipelined_signed_shift_divider.sv
// Streaming signed divide by 2^s: bias stage followed by a log2(N)-stage registered barrel shifter.
module pipelined_signed_shift_divider
   import shift_div_pkg::*;
#(
   parameter int N     = 8,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [N-1:0]         up_data,
   input  logic [$clog2(N)-1:0] up_shamt,
   input  mode_t                up_mode,
   input  logic [TAG_W-1:0]     up_tag,
   output logic                 down_valid,
   input  logic                 down_ready,
   output logic [N-1:0]         down_data,
   output logic [TAG_W-1:0]     down_tag
);

   localparam int SW = $clog2(N);

   if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("N must be a power of 2 and >= 2");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("TAG_W must be >= 1");
   end

   // Per-stage slot signals; index 0 is the bias stage, SW the output stage.
   logic [SW+1:0]            rdy;
   logic [SW:0]              vld;
   logic [SW:0][N:0]         dat;
   logic [SW:0][SW-1:0]      sha;
   logic [SW:0][TAG_W-1:0]   tag;

   logic                     s0_valid;
   logic [N:0]               s0_sum;
   logic [SW-1:0]            s0_shamt;
   logic [TAG_W-1:0]         s0_tag;
   logic signed [N:0]        sum;

   // N+1-bit sum cannot wrap: the largest bias is 2^(N-1) and only applies within range.
   assign sum = $signed({up_data[N-1], up_data})
              + (N+1)'(bias({{(BW-N){up_data[N-1]}}, up_data}, 32'(up_shamt), up_mode));

   assign rdy[0]      = !s0_valid || rdy[1];
   assign rdy[SW+1]   = down_ready;
   assign up_ready    = rdy[0];
   assign vld[0]      = s0_valid;
   assign dat[0]      = s0_sum;
   assign sha[0]      = s0_shamt;
   assign tag[0]      = s0_tag;

   // Bias stage: registers the extended sum together with shamt and tag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_sum   <= '0;
         s0_shamt <= '0;
         s0_tag   <= '0;
      end else if (rdy[0]) begin
         s0_valid <= up_valid;
         if (up_valid) begin
            s0_sum   <= sum;
            s0_shamt <= up_shamt;
            s0_tag   <= up_tag;
         end
      end
   end

   for (genvar k = 1; k <= SW; k++) begin : g_stage
      shift_div_stage #(
         .W     (N + 1),
         .DIST  (1 << (k - 1)),
         .TAG_W (TAG_W),
         .SW    (SW)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid   (vld[k-1]),
         .up_ready   (rdy[k]),
         .up_data    (dat[k-1]),
         .up_shamt   (sha[k-1]),
         .up_tag     (tag[k-1]),
         .down_valid (vld[k]),
         .down_ready (rdy[k+1]),
         .down_data  (dat[k]),
         .down_shamt (sha[k]),
         .down_tag   (tag[k])
      );
   end

   assign down_valid = vld[SW];
   assign down_data  = dat[SW][N-1:0];
   assign down_tag   = tag[SW];

endmodule
